nvram_shadow_ctrl: RTL and testbench
====================================

NVRAM_SHADOW_CTRL -- requirements
Module: nvram_shadow_ctrl

Interface
REQ-001 The block SHALL have the following ports, listed as name, direction, width and meaning:
- clk  in  1  system clock; the block has one clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- store_req  in  1  store request level (STORE & SIREn from top level); acts on its rising edge.
- recall_req  in  1  recall request level (~RECALLn & ~SIREn); acts on its rising edge.
- cpu_we  in  1  CPU write strobe into working NVRAM; used only for dirty tracking.
- work_addr  out  8  working-RAM address when busy=1.
- work_we  out  1  working-RAM write enable.
- work_wdata  out  8  working-RAM write data.
- work_rdata  in  8  working-RAM read data; synchronous, 1-cycle latency.
- shadow_addr  out  8  shadow-array address.
- shadow_we  out  1  shadow-array write enable.
- shadow_wdata  out  8  shadow-array write data.
- shadow_rdata  in  8  shadow-array read data; synchronous, 1-cycle latency.
- busy  out  1  high while the block owns both RAM ports; the top level muxes work_* onto the working RAM when busy=1.
- done  out  1  one-cycle pulse at the end of each operation.
- dirty  out  1  working RAM modified since the last store or recall.

Function
REQ-002 Edge detection SHALL use registered copies store_d and recall_d.
- Store edge: store_req=1 and store_d=0.
- Recall edge: recall_req=1 and recall_d=0.
REQ-003 The FSM SHALL have the states IDLE, READ, WRITE and DONE.
- An internal 1-bit dir SHALL select the direction: 0 = store (work->shadow), 1 = recall (shadow->work).
- An 8-bit cnt SHALL be the byte counter.
REQ-004 In IDLE, on a recall edge the FSM SHALL move to READ with dir=1 and cnt=0.
REQ-005 In IDLE, on a store edge with no recall edge in the same cycle, the FSM SHALL do one of the following:
- dirty=1: move to READ with dir=0 and cnt=0.
- dirty=0: move directly to DONE; no RAM write occurs.
REQ-006 A simultaneous store and recall edge SHALL be handled as a recall only; the store edge is discarded.
REQ-007 In READ, the source address SHALL equal cnt, and the FSM SHALL move to WRITE next cycle.
- dir=0: work_addr=cnt.
- dir=1: shadow_addr=cnt.
REQ-008 In WRITE, for exactly one cycle, the destination write enable SHALL be 1, the destination address SHALL equal cnt, and the write data SHALL equal the source rdata.
- dir=0: shadow_we=1.
- dir=1: work_we=1.
REQ-009 On leaving WRITE, the FSM SHALL go to DONE if cnt=255; otherwise it SHALL increment cnt and return to READ.
REQ-010 A full operation SHALL be 512 cycles in READ/WRITE followed by 1 cycle in DONE.
REQ-011 busy SHALL be 1 exactly in READ and WRITE.
REQ-012 done SHALL be 1 exactly in DONE; DONE SHALL always return to IDLE.
REQ-013 Request edges arriving in READ, WRITE or DONE SHALL be ignored, not queued.
- store_d and recall_d SHALL keep tracking the inputs, so a level held high across completion does not retrigger.
REQ-014 Write enables SHALL be 0 in IDLE, READ and DONE.
- Address and wdata outputs SHALL hold their last values when not in use.
REQ-015 dirty SHALL be set in any cycle with cpu_we=1, in every state.
REQ-016 dirty SHALL be cleared in DONE, with these exceptions:
- cpu_we=1 in that same DONE cycle: dirty stays 1.
- Store operation with cpu_we=1 in any cycle of it: dirty stays 1.
REQ-017 A recall SHALL clear dirty in DONE unless cpu_we=1 in the DONE cycle.
REQ-018 cnt SHALL wrap 255->0 only by going through DONE; it SHALL never exceed 8 bits.

Reset
REQ-019 Asserting reset SHALL immediately force the following, including mid-operation (partial copy abandoned, no further writes):
- state=IDLE, cnt=0, dir=0.
- busy=0, done=0, work_we=0, shadow_we=0.
- work_addr=0, shadow_addr=0, work_wdata=0, shadow_wdata=0.
REQ-020 Reset SHALL set dirty=1, so that the first store after power-up always executes.
REQ-021 Reset SHALL set store_d=1 and recall_d=1, so that request levels already high at reset release do not trigger an operation.

Verification
REQ-022 A bench SHALL cover these directed scenarios:
- Store: shadow preloaded 0x00, working[i]=i^0x5A, dirty=1, pulse store_req -> busy for 512 cycles, shadow[i]=i^0x5A for all i, done=1 for 1 cycle, dirty=0.
- Recall: shadow[i]=255-i, pulse recall_req -> working[i]=255-i, 256 work_we pulses, zero shadow_we pulses, dirty=0.
- Clean store: dirty=0, store edge -> done high the next cycle, busy never 1, no shadow_we.
- Priority: store_req and recall_req rise in the same cycle -> recall executes (dir=1); a second store_req edge at cycle 100 of the operation is ignored.
- Mid-operation reset: assert reset at cnt=0x80 during a store -> all write enables 0 immediately; shadow[0x00..0x7F] updated, shadow[0x80..0xFF] unchanged.
- Dirty during store: cpu_we pulse at cycle 300 of a store -> dirty=1 after done.

Source files
------------

// File: rtl/nvram_shadow_ctrl.sv
// Copies the 256-byte working NVRAM to its shadow array (store) or back (recall),
// one byte per READ/WRITE pair, and tracks whether working RAM is dirty.
module nvram_shadow_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       store_req,
  input  logic       recall_req,
  input  logic       cpu_we,
  output logic [7:0] work_addr,
  output logic       work_we,
  output logic [7:0] work_wdata,
  input  logic [7:0] work_rdata,
  output logic [7:0] shadow_addr,
  output logic       shadow_we,
  output logic [7:0] shadow_wdata,
  input  logic [7:0] shadow_rdata,
  output logic       busy,
  output logic       done,
  output logic       dirty
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t     state;
  logic       dir;        // 0: work->shadow, 1: shadow->work
  logic [7:0] cnt;
  logic       store_d, recall_d;
  logic       cpu_seen;
  logic [7:0] work_wdata_q, shadow_wdata_q;
  logic       store_edge, recall_edge;

  assign store_edge  = store_req  & ~store_d;
  assign recall_edge = recall_req & ~recall_d;

  // Source RAM data only arrives in the WRITE cycle, so write data passes
  // straight through there and is held from a register otherwise.
  assign work_wdata   = (state == WRITE &&  dir) ? shadow_rdata : work_wdata_q;
  assign shadow_wdata = (state == WRITE && !dir) ? work_rdata   : shadow_wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      dir            <= 1'b0;
      cnt            <= 8'h00;
      store_d        <= 1'b1;
      recall_d       <= 1'b1;
      cpu_seen       <= 1'b0;
      dirty          <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      work_we        <= 1'b0;
      shadow_we      <= 1'b0;
      work_addr      <= 8'h00;
      shadow_addr    <= 8'h00;
      work_wdata_q   <= 8'h00;
      shadow_wdata_q <= 8'h00;
    end else begin
      store_d  <= store_req;
      recall_d <= recall_req;

      // A store that saw a CPU write anywhere in it leaves the data dirty.
      if (cpu_we)
        dirty <= 1'b1;
      else if (state == DONE && !(!dir && cpu_seen))
        dirty <= 1'b0;

      case (state)
        IDLE: begin
          cpu_seen <= cpu_we;
          if (recall_edge) begin
            state       <= READ;
            dir         <= 1'b1;
            cnt         <= 8'h00;
            busy        <= 1'b1;
            shadow_addr <= 8'h00;
          end else if (store_edge) begin
            dir <= 1'b0;
            cnt <= 8'h00;
            if (dirty) begin
              state     <= READ;
              busy      <= 1'b1;
              work_addr <= 8'h00;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        READ: begin
          cpu_seen <= cpu_seen | cpu_we;
          state    <= WRITE;
          if (dir) begin
            work_addr <= cnt;
            work_we   <= 1'b1;
          end else begin
            shadow_addr <= cnt;
            shadow_we   <= 1'b1;
          end
        end
        WRITE: begin
          cpu_seen  <= cpu_seen | cpu_we;
          work_we   <= 1'b0;
          shadow_we <= 1'b0;
          if (dir) work_wdata_q   <= shadow_rdata;
          else     shadow_wdata_q <= work_rdata;
          if (cnt == 8'hFF) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt   <= cnt + 8'd1;
            state <= READ;
            if (dir) shadow_addr <= cnt + 8'd1;
            else     work_addr   <= cnt + 8'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          cnt   <= 8'h00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvram_shadow_ctrl.sv
// Scoreboard bench: stimulus pushes the expected outcome of each operation,
// a monitor pops it on done and compares counts, timing, dirty and RAM images.
module tb_nvram_shadow_ctrl;

  logic       clk, reset, store_req, recall_req, cpu_we;
  logic [7:0] work_addr, work_wdata, work_rdata;
  logic [7:0] shadow_addr, shadow_wdata, shadow_rdata;
  logic       work_we, shadow_we, busy, done, dirty;

  nvram_shadow_ctrl dut (
    .clk(clk), .reset(reset), .store_req(store_req), .recall_req(recall_req),
    .cpu_we(cpu_we), .work_addr(work_addr), .work_we(work_we),
    .work_wdata(work_wdata), .work_rdata(work_rdata), .shadow_addr(shadow_addr),
    .shadow_we(shadow_we), .shadow_wdata(shadow_wdata), .shadow_rdata(shadow_rdata),
    .busy(busy), .done(done), .dirty(dirty)
  );

  typedef struct packed {
    logic [255:0][7:0] shadow;
    logic [255:0][7:0] work;
    logic [9:0]        nbusy;
    logic [8:0]        nwwe;
    logic [8:0]        nswe;
    logic              dirty;
    logic [31:0]       done_cyc;
  } exp_t;

  exp_t       q[$];
  int         checks = 0, errors = 0, cyc = 0;
  bit         mon_chk = 0;
  logic       preload;
  logic [7:0] wmem[256], smem[256], pre_w[256], pre_s[256];
  logic [7:0] m_work[256], m_shadow[256];
  bit         m_dirty;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM models: working RAM is owned by the controller only while busy.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) begin
        wmem[i] <= pre_w[i];
        smem[i] <= pre_s[i];
      end
    end else begin
      if (busy && work_we) wmem[work_addr] <= work_wdata;
      if (shadow_we) smem[shadow_addr] <= shadow_wdata;
    end
    work_rdata   <= wmem[busy ? work_addr : 8'h00];
    shadow_rdata <= smem[shadow_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int shadow_diff(input exp_t e);
    int n = 0;
    for (int i = 0; i < 256; i++) if (smem[i] !== e.shadow[i]) n++;
    return n;
  endfunction

  function automatic int work_diff(input exp_t e);
    int n = 0;
    for (int i = 0; i < 256; i++) if (wmem[i] !== e.work[i]) n++;
    return n;
  endfunction

  // Monitor
  initial begin
    exp_t e;
    int nb = 0, nw = 0, ns = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        nb = 0; nw = 0; ns = 0;
      end else begin
        if (busy) nb++;
        if (work_we) nw++;
        if (shadow_we) ns++;
        if (done) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            mon_chk = 1;
            e = q.pop_front();
            chk("done_cycle", cyc, e.done_cyc);
            chk("busy_cycles", nb, e.nbusy);
            chk("work_we_pulses", nw, e.nwwe);
            chk("shadow_we_pulses", ns, e.nswe);
            @(negedge clk);
            chk("done_width", done, 0);
            chk("dirty_after", dirty, e.dirty);
            chk("shadow_image", shadow_diff(e), 0);
            chk("work_image", work_diff(e), 0);
            mon_chk = 0;
          end
          nb = 0; nw = 0; ns = 0;
        end
      end
    end
  end

  // Reference model: whole-array copies decided by the request and dirty flag.
  task automatic issue(input bit st, input bit rc, input bit cpu_mid);
    exp_t e;
    @(posedge clk); #2;
    store_req = st; recall_req = rc;
    e = '0;
    if (rc) begin
      for (int i = 0; i < 256; i++) m_work[i] = m_shadow[i];
      e.nbusy = 512; e.nwwe = 256;
      m_dirty = 0;
    end else if (m_dirty) begin
      for (int i = 0; i < 256; i++) m_shadow[i] = m_work[i];
      e.nbusy = 512; e.nswe = 256;
      m_dirty = cpu_mid;
    end else begin
      m_dirty = 0;
    end
    e.dirty = m_dirty;
    e.done_cyc = cyc + 1 + e.nbusy;
    for (int i = 0; i < 256; i++) begin
      e.shadow[i] = m_shadow[i];
      e.work[i]   = m_work[i];
    end
    q.push_back(e);
    @(posedge clk); #2;
    store_req = 0; recall_req = 0;
  endtask

  task automatic wait_op();
    bit ok = 0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      if (q.size() == 0 && !mon_chk) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("op_timeout", q.size(), 0);
      q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic do_preload(input bit cpu);
    @(posedge clk); #2;
    for (int i = 0; i < 256; i++) begin
      pre_w[i] = m_work[i];
      pre_s[i] = m_shadow[i];
    end
    preload = 1; cpu_we = cpu;
    @(posedge clk); #2;
    preload = 0; cpu_we = 0;
    if (cpu) m_dirty = 1;
  endtask

  initial begin
    bit found;
    reset = 1; store_req = 1; recall_req = 0; cpu_we = 0; preload = 0;
    m_dirty = 1;
    #3;
    chk("rst_ctrl", {busy, done, work_we, shadow_we}, 4'b0000);
    chk("rst_addr_data", {work_addr, shadow_addr, work_wdata, shadow_wdata}, 32'h0);
    chk("rst_dirty", dirty, 1);
    repeat (3) @(posedge clk); #2;
    reset = 0;
    // store_req already high at release must not start anything
    repeat (10) @(posedge clk);
    #1 chk("level_at_release", {busy, done}, 2'b00);
    store_req = 0;

    // Directed store
    for (int i = 0; i < 256; i++) begin
      m_work[i] = 8'(i) ^ 8'h5A;
      m_shadow[i] = 8'h00;
    end
    do_preload(1);
    issue(1, 0, 0);
    wait_op();

    // Clean store
    issue(1, 0, 0);
    wait_op();

    // Directed recall
    for (int i = 0; i < 256; i++) m_shadow[i] = 8'(255 - i);
    do_preload(0);
    issue(0, 1, 0);
    wait_op();

    // Simultaneous edges, then a store edge mid-operation held past done
    for (int i = 0; i < 256; i++) m_shadow[i] = 8'($urandom);
    do_preload(0);
    issue(1, 1, 0);
    repeat (97) @(posedge clk); #2;
    store_req = 1;
    wait_op();
    repeat (5) @(posedge clk);
    #1 chk("no_retrigger", {busy, done}, 2'b00);
    store_req = 0;

    // CPU write in the middle of a store
    for (int i = 0; i < 256; i++) m_work[i] = 8'($urandom);
    do_preload(1);
    issue(1, 0, 1);
    repeat (298) @(posedge clk); #2;
    cpu_we = 1;
    @(posedge clk); #2;
    cpu_we = 0;
    wait_op();

    // Reset in the middle of a store at cnt=0x80
    for (int i = 0; i < 256; i++) m_work[i] = 8'($urandom);
    do_preload(1);
    @(posedge clk); #2 store_req = 1;
    @(posedge clk); #2 store_req = 0;
    found = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (busy && work_addr == 8'h80 && !shadow_we) begin found = 1; break; end
    end
    chk("reach_cnt_80", found, 1);
    reset = 1;
    #1;
    chk("midrst_ctrl", {busy, done, work_we, shadow_we}, 4'b0000);
    chk("midrst_dirty", dirty, 1);
    repeat (2) @(posedge clk); #2;
    reset = 0;
    for (int i = 0; i < 128; i++) m_shadow[i] = m_work[i];
    m_dirty = 1;
    begin
      int n = 0;
      for (int i = 0; i < 256; i++) if (smem[i] !== m_shadow[i]) n++;
      chk("midrst_shadow_image", n, 0);
    end

    // Randomized operations
    for (int k = 0; k < 6; k++) begin
      bit c;
      int op;
      c = 1'($urandom_range(0, 1));
      if (c) for (int i = 0; i < 256; i++) m_work[i] = 8'($urandom);
      if ($urandom_range(0, 1) == 1) for (int i = 0; i < 256; i++) m_shadow[i] = 8'($urandom);
      do_preload(c);
      op = $urandom_range(0, 2);
      issue(op != 1, op != 0, 0);
      wait_op();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
